qu_issue_sched: RTL

QU_ISSUE_SCHED -- requirements
Module: qu_issue_sched

---
 rtl/qu_uop_pkg.sv | 42 ++++
 rtl/qu_prio_sel.sv | 28 ++
 rtl/qu_issue_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/qu_uop_pkg.sv
// Shared uop definitions for the issue stage: physical register width, uop layouts
// and the issue-queue entry record.
package qu_uop;

  localparam int PHY_RF_ADDR_WIDTH = 6;
  localparam int UOP_WIDTH         = 32;
  localparam int IQ_DEPTH          = 8;

  typedef struct packed {
    logic [3:0]                   opcode;
    logic [PHY_RF_ADDR_WIDTH-1:0] rd;
    logic [PHY_RF_ADDR_WIDTH-1:0] rs1;
    logic                         rs1_valid;
    logic [PHY_RF_ADDR_WIDTH-1:0] rs2;
    logic                         rs2_valid;
    logic [7:0]                   imm;
  } uop_ic_t;

  typedef struct packed {
    logic [3:0]                   opcode;
    logic [PHY_RF_ADDR_WIDTH-1:0] rd;
    logic [PHY_RF_ADDR_WIDTH-1:0] rs1;
    logic                         rs1_valid;
    logic [PHY_RF_ADDR_WIDTH-1:0] rs2;
    logic                         rs2_valid;
    logic [1:0]                   size;
    logic [5:0]                   offset;
  } uop_ldst_t;

  typedef union packed {
    uop_ic_t   uop_ic;
    uop_ldst_t uop_ldst;
  } uop_t;

  typedef struct packed {
    logic valid;
    uop_t uop;
    logic rs1_rdy;
    logic rs2_rdy;
  } iq_entry_t;

endpackage

// File: rtl/qu_prio_sel.sv
// Oldest-first selector: lowest set request wins; one-hot grant plus binary index.
module qu_prio_sel #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         req,
  output logic [DEPTH-1:0]         grant,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     any
);

  localparam int IW = $clog2(DEPTH);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Scan from the top so the lowest-index request is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qu_issue_sched.sv
// Collapsing issue queue with writeback wakeup and a single oldest-first issue register.
module qu_issue_sched
  import qu_uop::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enq_valid,
  output logic                             enq_ready,
  input  uop_t                             enq_uop,
  input  logic                             enq_rs1_rdy,
  input  logic                             enq_rs2_rdy,
  input  logic                             wb_valid,
  input  logic [PHY_RF_ADDR_WIDTH-1:0]     wb_tag,
  output logic                             iss_valid,
  input  logic                             iss_ready,
  output uop_t                             iss_uop,
  input  logic                             flush,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  iq_entry_t               q     [DEPTH];
  iq_entry_t               q_nxt [DEPTH];
  iq_entry_t               woke  [DEPTH+1];
  iq_entry_t               new_e;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_nxt;
  logic [CW-1:0]           enq_pos;
  logic [DEPTH-1:0]        req;
  logic [DEPTH-1:0]        grant;
  logic [IW-1:0]           sel_idx;
  logic                    sel_any;
  logic                    enq_fire;
  logic                    move;
  uop_t                    sel_uop;

  function automatic logic tag_hit(input logic                         wbv,
                                   input logic [PHY_RF_ADDR_WIDTH-1:0] wt,
                                   input logic [PHY_RF_ADDR_WIDTH-1:0] rs,
                                   input logic                         rsv);
    return rsv && wbv && (wt == rs);
  endfunction

  assign count     = count_q;
  assign enq_ready = (count_q < CW'(DEPTH)) && !flush;
  assign enq_fire  = enq_valid && enq_ready;
  assign move      = sel_any && (!iss_valid || iss_ready);
  assign enq_pos   = count_q - CW'(move);

  // Eligibility uses registered readiness only; a wakeup issues the cycle after.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      req[i] = q[i].valid && q[i].rs1_rdy && q[i].rs2_rdy;
  end

  qu_prio_sel #(.DEPTH(DEPTH)) u_prio_sel (
    .req   (req),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    sel_uop = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) sel_uop = sel_uop | q[i].uop;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = q[i];
      if (q[i].valid) begin
        woke[i].rs1_rdy = q[i].rs1_rdy ||
          tag_hit(wb_valid, wb_tag, q[i].uop.uop_ic.rs1, q[i].uop.uop_ic.rs1_valid);
        woke[i].rs2_rdy = q[i].rs2_rdy ||
          tag_hit(wb_valid, wb_tag, q[i].uop.uop_ic.rs2, q[i].uop.uop_ic.rs2_valid);
      end
    end
    woke[DEPTH] = '0;

    // Catch a writeback landing in the enqueue cycle so the wakeup is not lost.
    new_e.valid   = 1'b1;
    new_e.uop     = enq_uop;
    new_e.rs1_rdy = !enq_uop.uop_ic.rs1_valid || enq_rs1_rdy ||
                    tag_hit(wb_valid, wb_tag, enq_uop.uop_ic.rs1, 1'b1);
    new_e.rs2_rdy = !enq_uop.uop_ic.rs2_valid || enq_rs2_rdy ||
                    tag_hit(wb_valid, wb_tag, enq_uop.uop_ic.rs2, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      if (move && (i >= int'(sel_idx))) q_nxt[i] = woke[i+1];
      else                              q_nxt[i] = woke[i];
      if (enq_fire && (i == int'(enq_pos))) q_nxt[i] = new_e;
    end

    count_nxt = count_q + CW'(enq_fire) - CW'(move);
  end

  // Queue stage: only valid bits are cleared; payloads are don't-care when invalid.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
      count_q <= '0;
    end else begin
      q       <= q_nxt;
      count_q <= count_nxt;
    end
  end

  // Issue stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_uop   <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (move) begin
      iss_valid <= 1'b1;
      iss_uop   <= sel_uop;
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

endmodule
